// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 64;
  localparam int INS_W_DEF  = 32;
  localparam int PC_STEP    = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Control, memory and decode-side handshake signals of the fetch controller.
interface fetch_controller_if #(
  parameter int ADDR_W = 64,
  parameter int INS_W  = 32
);
  logic              start;
  logic              stop;
  logic              brValid;
  logic [ADDR_W-1:0] brTarget;
  logic [ADDR_W-1:0] insAdd;
  logic [INS_W-1:0]  ins;
  logic              outValid;
  logic              outReady;
  logic [INS_W-1:0]  outIns;
  logic [ADDR_W-1:0] outPc;
  logic              running;
  logic              fault;

  modport master (
    input  start, stop, brValid, brTarget, ins, outReady,
    output insAdd, outValid, outIns, outPc, running, fault
  );

  modport slave (
    output start, stop, brValid, brTarget, ins, outReady,
    input  insAdd, outValid, outIns, outPc, running, fault
  );
endinterface

// File: rtl/fetch_controller_buffer.sv
// Two-entry FIFO of {pc, ins}; head is read straight from registers.
module fetch_buffer #(
  parameter int ADDR_W    = 64,
  parameter int INS_W     = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INS_W-1:0]  ins_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [INS_W-1:0]  head_ins_o
);

  if (BUF_DEPTH != 2) begin : g_depth_check
    $error("fetch_buffer supports BUF_DEPTH == 2 only");
  end

  logic [ADDR_W-1:0] pc_q  [2];
  logic [INS_W-1:0]  ins_q [2];
  logic              head_q, head_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              tail;
  logic              do_pop;

  // With cnt==2 the tail slot is the head slot, which a same-cycle pop frees.
  always_comb begin
    tail   = head_q ^ cnt_q[0];
    do_pop = pop_i && (cnt_q != 2'd0);
    head_d = head_q ^ do_pop;
    cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        pc_q[tail]  <= pc_i;
        ins_q[tail] <= ins_i;
      end
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);
  assign head_pc_o  = pc_q[head_q];
  assign head_ins_o = ins_q[head_q];

endmodule

// File: rtl/fetch_controller.sv
// PC sequencer: fetches from a combinational instruction memory into a 2-entry buffer.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                INS_W     = INS_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input logic                clk,
  input logic                rstN,
  fetch_controller_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              running_q;
  logic              fault_q;

  logic full, empty, pop, fire, redirect, bad_target;
  logic [ADDR_W-1:0] head_pc;
  logic [INS_W-1:0]  head_ins;

  // A redirect outranks fetch and pop; FAULT ignores further redirects.
  always_comb begin
    redirect   = bus.brValid && (state_q != FAULT);
    bad_target = misaligned(bus.brTarget[1:0]);
    pop        = !empty && bus.outReady;
    fire       = (state_q == RUN) && !bus.brValid && (!full || pop);
    pc_d       = pc_q;
    if (redirect && !bad_target) begin
      pc_d = bus.brTarget;
    end else if (fire) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (redirect && bad_target) begin
        state_q   <= FAULT;
        running_q <= 1'b0;
        fault_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (bus.start && !bus.stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          RUN: if (bus.stop) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  fetch_buffer #(
    .ADDR_W    (ADDR_W),
    .INS_W     (INS_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rstN       (rstN),
    .push_i     (fire),
    .pop_i      (pop),
    .flush_i    (redirect),
    .pc_i       (pc_q),
    .ins_i      (bus.ins),
    .full_o     (full),
    .empty_o    (empty),
    .head_pc_o  (head_pc),
    .head_ins_o (head_ins)
  );

  assign bus.insAdd   = pc_q;
  assign bus.outValid = !empty;
  assign bus.outIns   = head_ins;
  assign bus.outPc    = head_pc;
  assign bus.running  = running_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FAULT = 2;

  logic clk;
  logic rstN;
  logic [7:0] mem [16];

  fetch_controller_if #(.ADDR_W(64), .INS_W(32)) bus ();

  fetch_controller #(
    .ADDR_W    (64),
    .INS_W     (32),
    .RESET_PC  (64'd0),
    .BUF_DEPTH (2)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [63:0] a);
    logic [3:0] b;
    b = a[3:0];
    return {mem[b + 4'd3], mem[b + 4'd2], mem[b + 4'd1], mem[b]};
  endfunction

  assign bus.ins = memword(bus.insAdd);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model: state, PC, fault flag and an in-order queue of fetched words.
  int          m_state;
  logic [63:0] m_pc;
  logic        m_fault;
  logic [63:0] q_pc [$];
  logic [31:0] q_ins [$];

  task automatic check_outputs();
    chk("insAdd", bus.insAdd, m_pc);
    chk("outValid", 64'(bus.outValid), 64'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      chk("outPc", bus.outPc, q_pc[0]);
      chk("outIns", 64'(bus.outIns), 64'(q_ins[0]));
    end
    chk("running", 64'(bus.running), 64'(m_state == S_RUN));
    chk("fault", 64'(bus.fault), 64'(m_fault));
  endtask

  task automatic cyc();
    int          nst;
    logic [63:0] npc;
    logic        nf;
    bit          pop;
    bit          fire;
    nst  = m_state;
    npc  = m_pc;
    nf   = m_fault;
    pop  = (q_pc.size() > 0) && bus.outReady;
    fire = 1'b0;
    if (bus.brValid && m_state != S_FAULT) begin
      q_pc.delete();
      q_ins.delete();
      if (bus.brTarget[1:0] != 2'b00) begin
        nst = S_FAULT;
        nf  = 1'b1;
      end else begin
        npc = bus.brTarget;
      end
    end else begin
      fire = (m_state == S_RUN) && !bus.brValid && (q_pc.size() < 2 || pop);
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (fire) begin
        q_pc.push_back(m_pc);
        q_ins.push_back(memword(m_pc));
        npc = m_pc + 64'd4;
      end
    end
    if (nst != S_FAULT) begin
      if (m_state == S_IDLE && bus.start && !bus.stop) nst = S_RUN;
      else if (m_state == S_RUN && bus.stop) nst = S_IDLE;
    end
    @(posedge clk);
    #1;
    m_state = nst;
    m_pc    = npc;
    m_fault = nf;
    check_outputs();
  endtask

  task automatic apply_reset();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.brValid  = 1'b0;
    bus.brTarget = '0;
    bus.outReady = 1'b0;
    rstN = 1'b0;
    #1;
    chk("rst_outValid", 64'(bus.outValid), 64'd0);
    chk("rst_outIns", 64'(bus.outIns), 64'd0);
    chk("rst_outPc", bus.outPc, 64'd0);
    chk("rst_running", 64'(bus.running), 64'd0);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_insAdd", bus.insAdd, 64'd0);
    m_state = S_IDLE;
    m_pc    = 64'd0;
    m_fault = 1'b0;
    q_pc.delete();
    q_ins.delete();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  logic [31:0] t1_exp [5] = '{32'h03020100, 32'h07060504, 32'h0B0A0908,
                              32'h0F0E0D0C, 32'h03020100};

  initial begin
    logic [63:0] exp_pc;
    int          fault_age;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    apply_reset();

    // Streaming with outReady held high, including the 16-byte wrap.
    bus.outReady = 1'b1;
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t1_ins", 64'(bus.outIns), 64'(t1_exp[i]));
      chk("t1_pc", bus.outPc, 64'(i * 4));
    end

    // Backpressure then release: head holds, PC parks at 8, order preserved.
    apply_reset();
    start_pulse();
    repeat (5) cyc();
    chk("t2_head_ins", 64'(bus.outIns), 64'h03020100);
    chk("t2_head_pc", bus.outPc, 64'd0);
    chk("t2_pc_park", bus.insAdd, 64'd8);
    bus.outReady = 1'b1;
    exp_pc = 64'd0;
    for (int i = 0; i < 6; i++) begin
      if (bus.outValid) begin
        chk("t2_order", bus.outPc, exp_pc);
        exp_pc += 64'd4;
      end
      cyc();
    end

    // Aligned redirect with a pop in the same cycle.
    bus.brValid  = 1'b1;
    bus.brTarget = 64'd8;
    cyc();
    bus.brValid = 1'b0;
    chk("t3_flush", 64'(bus.outValid), 64'd0);
    cyc();
    chk("t3_ins", 64'(bus.outIns), 64'h0B0A0908);
    chk("t3_pc", bus.outPc, 64'd8);

    // Misaligned redirect: sticky fault, start ignored until reset.
    bus.brValid  = 1'b1;
    bus.brTarget = 64'd6;
    cyc();
    bus.brValid = 1'b0;
    chk("t4_fault", 64'(bus.fault), 64'd1);
    chk("t4_running", 64'(bus.running), 64'd0);
    chk("t4_outValid", 64'(bus.outValid), 64'd0);
    start_pulse();
    cyc();
    chk("t4_fault_sticky", 64'(bus.fault), 64'd1);
    chk("t4_no_restart", 64'(bus.running), 64'd0);
    apply_reset();

    // Stop with a full buffer: entries drain, PC stays put.
    start_pulse();
    cyc();
    cyc();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("t5_running", 64'(bus.running), 64'd0);
    chk("t5_pc", bus.insAdd, 64'd8);
    bus.outReady = 1'b1;
    cyc();
    cyc();
    chk("t5_drained", 64'(bus.outValid), 64'd0);
    chk("t5_pc_hold", bus.insAdd, 64'd8);

    // Asynchronous reset in the middle of a cycle with a full buffer.
    apply_reset();
    start_pulse();
    cyc();
    cyc();
    chk("t6_full", 64'(bus.outValid), 64'd1);
    #2;
    apply_reset();

    // Randomized traffic with random memory contents.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    apply_reset();
    fault_age = 0;
    for (int i = 0; i < 1500; i++) begin
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.stop     = ($urandom_range(0, 19) == 0);
      bus.brValid  = ($urandom_range(0, 15) == 0);
      bus.outReady = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       bus.brTarget = {$urandom, $urandom} | 64'd1;
        1:       bus.brTarget = 64'hFFFF_FFFF_FFFF_FFF8;
        default: bus.brTarget = {$urandom, $urandom} & ~64'd3;
      endcase
      cyc();
      if (m_state == S_FAULT) fault_age++;
      if (fault_age > 4) begin
        fault_age = 0;
        #2;
        apply_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Program-counter sequencer that drives the address input of `instructionMemory` and captures the returned 32-bit word. Fetched words are passed to decode through a 2-entry buffer with a valid/ready handshake. Supports start/stop control, branch redirect with flush, and a sticky fault on misaligned targets. Sits between `instructionMemory` and the decode stage.

Parameters:
ADDR_W, 64, width of the PC and the memory address bus
INS_W, 32, instruction width
RESET_PC, 0, PC value loaded at reset
BUF_DEPTH, 2, instruction buffer entries; fixed at 2 and checked at elaboration

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  pulse: IDLE -> RUN
stop  input  1  pulse: RUN -> IDLE; buffer is kept and still drains
brValid  input  1  redirect request, 1-cycle pulse
brTarget  input  ADDR_W  redirect target PC
insAdd  output  ADDR_W  address to `instructionMemory`; equals PC register
ins  input  INS_W  word returned combinationally by `instructionMemory`
outValid  output  1  buffer head is valid
outReady  input  1  decode accepts head
outIns  output  INS_W  head instruction
outPc  output  ADDR_W  PC of head instruction
running  output  1  state == RUN
fault  output  1  sticky misaligned-redirect flag

Behaviour:
- Reset (asynchronous, rstN=0):
  - PC = RESET_PC, buffer empty, state IDLE.
  - outValid=0, outIns=0, outPc=0, running=0, fault=0, insAdd=RESET_PC.
- Memory timing: read is combinational. `ins` is sampled in the same cycle insAdd=PC, so fetch-to-buffer latency is 1 clk.
- Fetch condition, `fire`: state==RUN, no brValid this cycle, and the buffer is not full or a pop occurs this cycle.
- On fire:
  - push {PC, ins} into the buffer;
  - PC <= PC+4, modulo 2^ADDR_W, with no saturation.
  - Memory indexing wraps naturally on insAdd[3:0]: PC 12 -> 16 reads bytes 0..3.
- Pop: occurs when outValid && outReady. Head advances; a simultaneous push and pop is allowed, including when the buffer is full.
- Throughput: 1 instruction per clk with outReady held high. The first outValid appears 1 clk after RUN is entered.
- Redirect (brValid=1), highest priority:
  - If brTarget[1:0]==0: flush the buffer (outValid=0 next cycle), PC <= brTarget, no push this cycle. A pop in the same cycle is ignored because of the flush.
  - If brTarget[1:0]!=0: state -> FAULT, fault=1, buffer flushed, PC unchanged.
  - brValid in IDLE: PC is updated (or FAULT entered), with no fetch.
- State machine:
  - IDLE: start -> RUN; stop ignored.
  - RUN: stop -> IDLE. If start and stop arrive together, stop wins.
  - FAULT: absorbing until reset. No fetch, start ignored, outValid=0.
- Stop: fetching ceases from the next cycle; already buffered entries still present and pop normally.
- Buffer: 2 entries, pointer + count. Outputs are driven from registers; outIns/outPc are held stable while outValid && !outReady.
- Mid-operation reset: asserting rstN=0 forces all reset values immediately, without waiting for a clock edge.

Decomposition:
- fetch_pkg:
  - state enum {IDLE, RUN, FAULT}
  - ADDR_W/INS_W defaults
  - PC_STEP=4
  - ALIGN_MASK=2'b11
- Sub-module fetch_buffer: 2-entry FIFO carrying {pc, ins}. Interface: push/pop/flush/full/empty/head. The top module holds the FSM and PC.

Test Plan:
1. Reset with a 16-byte memory loaded memReg[i]=i, then start, outReady=1 -> outIns sequence 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, 0x03020100 (wrap); outPc 0,4,8,12,16; one per clk after a 1-clk latency.
2. Backpressure: start, outReady=0 for 5 clk -> outValid=1, head holds 0x03020100/pc 0, PC stops at 8 (buffer full). Release -> in-order delivery with no loss or duplicate.
3. Redirect: while running, brValid with brTarget=8 -> next cycle outValid=0; the following cycle outIns=0x0B0A0908, outPc=8. A pop in the redirect cycle is discarded.
4. Misaligned redirect: brTarget=6 -> fault=1, running=0, outValid=0. A later start has no effect until rstN pulses low, after which fault=0.
5. Stop with a full buffer: stop while holding 2 entries -> no new fetch, both entries drain on outReady, running=0, PC unchanged.
6. Asynchronous reset mid-cycle while running with a full buffer -> outValid=0 and insAdd=RESET_PC immediately, before the next clk edge.
